// File: rtl/bit_scan_pkg.sv
// Shared types and constants for the bit-scan sequencer and its helpers.
package bit_scan_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [2:0] LAST_INDEX = 3'd6;
   localparam int         NUM_BITS   = 7;
endpackage

// File: rtl/bit_scan_sequencer_if.sv
// Control/status bundle between the sequencer and whoever drives the scan.
interface bit_scan_sequencer_if;
   import bit_scan_pkg::*;

   logic                start;
   logic                loop;
   logic [NUM_BITS-1:0] data_in;
   logic [2:0]          mux_select;
   logic                serial_out;
   logic                bit_tick;
   logic                busy;
   logic                done;

   modport master (
      output start, loop, data_in,
      input  mux_select, serial_out, bit_tick, busy, done
   );

   modport slave (
      input  start, loop, data_in,
      output mux_select, serial_out, bit_tick, busy, done
   );
endinterface

// File: rtl/mux7to1.sv
// 7-to-1 bit multiplexer; the unused select code 7 yields 0.
module mux7to1 (
   input  logic [6:0] data,
   input  logic [2:0] sel,
   output logic       y
);
   always_comb begin
      y = 1'b0;
      case (sel)
         3'd0:    y = data[0];
         3'd1:    y = data[1];
         3'd2:    y = data[2];
         3'd3:    y = data[3];
         3'd4:    y = data[4];
         3'd5:    y = data[5];
         3'd6:    y = data[6];
         default: y = 1'b0;
      endcase
   end
endmodule

// File: rtl/rate_divider.sv
// Loadable down-counter that parks at zero; zero flag is decoded from the register.
module rate_divider #(
   parameter int CNT_W = 1
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic [CNT_W-1:0] reload,
   input  logic             load,
   input  logic             enable,
   output logic             zero
);
   logic [CNT_W-1:0] count_reg;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         count_reg <= '0;
      end else if (load) begin
         count_reg <= reload;
      end else if (enable && (count_reg != '0)) begin
         count_reg <= count_reg - CNT_W'(1);
      end
   end

   assign zero = (count_reg == '0);
endmodule

// File: rtl/bit_scan_sequencer.sv
// Captures a 7-bit pattern on start and walks the mux select 0..6, holding each
// index CYCLES_PER_BIT cycles, optionally wrapping while loop is high.
module bit_scan_sequencer
   import bit_scan_pkg::*;
#(
   parameter int CYCLES_PER_BIT = 25000000,
   parameter int CNT_W          = $clog2(CYCLES_PER_BIT) + 1
) (
   input  logic                 clk,
   input  logic                 resetn,
   bit_scan_sequencer_if.slave  bus
);
   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CYCLES_PER_BIT - 1);

   state_t              state_reg, state_next;
   logic [NUM_BITS-1:0] pattern_reg, pattern_next;
   logic [2:0]          sel_reg, sel_next;
   logic                load;
   logic                enable;
   logic                count_zero;
   logic                mux_bit;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_reg   <= IDLE;
         pattern_reg <= '0;
         sel_reg     <= 3'd0;
      end else begin
         state_reg   <= state_next;
         pattern_reg <= pattern_next;
         sel_reg     <= sel_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      pattern_next = pattern_reg;
      sel_next     = sel_reg;
      load         = 1'b0;
      enable       = 1'b0;
      case (state_reg)
         IDLE: begin
            if (bus.start) begin
               pattern_next = bus.data_in;
               sel_next     = 3'd0;
               load         = 1'b1;
               state_next   = RUN;
            end
         end
         RUN: begin
            enable = 1'b1;
            if (count_zero) begin
               if (sel_reg != LAST_INDEX) begin
                  sel_next = sel_reg + 3'd1;
                  load     = 1'b1;
               end else if (bus.loop) begin
                  sel_next = 3'd0;
                  load     = 1'b1;
               end else begin
                  // Counter is left at zero; it is reloaded on the next start.
                  sel_next   = 3'd0;
                  state_next = DONE;
               end
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   rate_divider #(
      .CNT_W (CNT_W)
   ) u_rate_divider (
      .clk    (clk),
      .resetn (resetn),
      .reload (RELOAD),
      .load   (load),
      .enable (enable),
      .zero   (count_zero)
   );

   mux7to1 u_mux (
      .data (pattern_reg),
      .sel  (sel_reg),
      .y    (mux_bit)
   );

   assign bus.busy       = (state_reg == RUN);
   assign bus.done       = (state_reg == DONE);
   assign bus.bit_tick   = (state_reg == RUN) && count_zero;
   assign bus.mux_select = sel_reg;
   assign bus.serial_out = mux_bit && (state_reg == RUN);
endmodule

// File: tb/tb_bit_scan_sequencer.sv
// Drives two sequencers (4 and 1 cycles per bit) with shared stimulus and checks
// every cycle against a flat scan-position model.
module tb_bit_scan_sequencer;
   localparam int CPB_A = 4;
   localparam int CPB_B = 1;

   logic       clk = 1'b0;
   logic       resetn;
   logic       start;
   logic       loop;
   logic [6:0] data_in;

   always #5 clk = ~clk;

   bit_scan_sequencer_if bus_a ();
   bit_scan_sequencer_if bus_b ();

   assign bus_a.start   = start;
   assign bus_a.loop    = loop;
   assign bus_a.data_in = data_in;
   assign bus_b.start   = start;
   assign bus_b.loop    = loop;
   assign bus_b.data_in = data_in;

   bit_scan_sequencer #(.CYCLES_PER_BIT(CPB_A)) dut_a (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus_a)
   );

   bit_scan_sequencer #(.CYCLES_PER_BIT(CPB_B)) dut_b (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus_b)
   );

   // Model: mode 0 idle, 1 scanning (pos = cycles since scan start, 0..7*cpb-1), 2 done cycle.
   int         m_mode [2];
   int         m_pos  [2];
   logic [6:0] m_pat  [2];

   int checks = 0;
   int errors = 0;
   int cycle  = 0;

   function automatic int cpb_of(input int k);
      return (k == 0) ? CPB_A : CPB_B;
   endfunction

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, cycle, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_mode[k] = 0;
         m_pos[k]  = 0;
         m_pat[k]  = 7'd0;
      end
   endtask

   task automatic model_edge();
      for (int k = 0; k < 2; k++) begin
         case (m_mode[k])
            0: if (start) begin
                  m_mode[k] = 1;
                  m_pos[k]  = 0;
                  m_pat[k]  = data_in;
               end
            1: if (m_pos[k] == 7 * cpb_of(k) - 1) begin
                  if (loop) m_pos[k] = 0;
                  else      m_mode[k] = 2;
               end else begin
                  m_pos[k] = m_pos[k] + 1;
               end
            default: m_mode[k] = 0;
         endcase
      end
   endtask

   task automatic compare_all();
      for (int k = 0; k < 2; k++) begin
         int    c;
         int    idx;
         int    act;
         int    o_busy, o_done, o_tick, o_sel, o_ser;
         string p;
         c   = cpb_of(k);
         act = (m_mode[k] == 1) ? 1 : 0;
         idx = act ? (m_pos[k] / c) : 0;
         p   = (k == 0) ? "a" : "b";
         o_busy = (k == 0) ? int'(bus_a.busy)       : int'(bus_b.busy);
         o_done = (k == 0) ? int'(bus_a.done)       : int'(bus_b.done);
         o_tick = (k == 0) ? int'(bus_a.bit_tick)   : int'(bus_b.bit_tick);
         o_sel  = (k == 0) ? int'(bus_a.mux_select) : int'(bus_b.mux_select);
         o_ser  = (k == 0) ? int'(bus_a.serial_out) : int'(bus_b.serial_out);
         check({p, ".busy"},       o_busy, act);
         check({p, ".done"},       o_done, (m_mode[k] == 2) ? 1 : 0);
         check({p, ".bit_tick"},   o_tick, (act != 0 && (m_pos[k] % c) == c - 1) ? 1 : 0);
         check({p, ".mux_select"}, o_sel,  idx);
         check({p, ".serial_out"}, o_ser,  act ? int'(m_pat[k][idx]) : 0);
         if (o_done != 0)
            $display("dut_%s scan complete at cycle %0d", p, cycle);
      end
   endtask

   task automatic step(input logic s, input logic l, input logic [6:0] d);
      start   = s;
      loop    = l;
      data_in = d;
      @(posedge clk);
      model_edge();
      cycle++;
      @(negedge clk);
      compare_all();
   endtask

   initial begin
      resetn  = 1'b0;
      start   = 1'b0;
      loop    = 1'b0;
      data_in = 7'd0;
      model_reset();
      repeat (2) @(negedge clk);
      compare_all();
      resetn = 1'b1;

      // Basic scan, with start/data re-asserted around index 2 of dut_a
      step(1'b1, 1'b0, 7'b1010011);
      repeat (9) step(1'b0, 1'b0, 7'd0);
      repeat (3) step(1'b1, 1'b0, 7'h7F);
      repeat (25) step(1'b0, 1'b0, 7'd0);

      // Loop mode, loop dropped while dut_a sits at index 4 of its second pass
      step(1'b1, 1'b1, 7'b0000001);
      repeat (45) step(1'b0, 1'b1, 7'd0);
      repeat (40) step(1'b0, 1'b0, 7'd0);

      // Alternating pattern, mainly for the one-cycle-per-bit instance
      step(1'b1, 1'b0, 7'b0101010);
      repeat (34) step(1'b0, 1'b0, 7'd0);

      // Start held high: back-to-back scans
      repeat (80) step(1'b1, 1'b0, 7'($urandom));
      repeat (35) step(1'b0, 1'b0, 7'd0);

      // Randomized traffic
      loop = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         logic l;
         l = loop;
         if ($urandom_range(0, 49) == 0) l = ~l;
         step(($urandom_range(0, 7) == 0), l, 7'($urandom));
      end
      repeat (40) step(1'b0, 1'b0, 7'd0);

      // Asynchronous reset mid-scan (dut_a at index 3)
      step(1'b1, 1'b0, 7'b1111111);
      repeat (13) step(1'b0, 1'b0, 7'd0);
      #2;
      resetn = 1'b0;
      #1;
      model_reset();
      compare_all();
      @(posedge clk);
      @(negedge clk);
      compare_all();
      resetn = 1'b1;
      repeat (10) step(1'b0, 1'b0, 7'h55);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
